// File: rtl/btn_pkg.sv
// ---------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the push-button conditioner:
//   - btn_state_e : 2-bit FSM encoding (IDLE=0, PRESS_WAIT=1, HELD=2,
//                   RELEASE_WAIT=3)
//   - default DEBOUNCE_CYCLES values for the board clock and for simulation
// ---------------------------------------------------------------------------
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  // Roughly 5 ms at a 50 MHz board clock.
  localparam int unsigned DEBOUNCE_CYCLES_BOARD = 250000;
  // Short window so simulations finish quickly.
  localparam int unsigned DEBOUNCE_CYCLES_SIM   = 4;

endpackage

// File: rtl/btn_conditioner_sync2.sv
// ---------------------------------------------------------------------------
// sync2
// Generic two-flop synchronizer for a single asynchronous bit. Nothing sits
// between the two flops so the first one gets a full cycle to settle.
// Ports:
//   clk   : destination clock
//   rst_n : synchronous active-low reset, loads RESET_VAL into both flops
//   d     : asynchronous input
//   q     : synchronized output (two cycles of latency)
// Parameters:
//   RESET_VAL : value both flops take during reset
// ---------------------------------------------------------------------------
module sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/btn_conditioner.sv
// ---------------------------------------------------------------------------
// btn_conditioner
// Turns a raw, bouncing, asynchronous push-button pin into a one-cycle `go`
// pulse on each accepted press, a debounced `pressed` level and a one-cycle
// `release_o` pulse on each accepted release.
// Ports:
//   clk       : system clock
//   rst_btn   : synchronous active-low reset
//   btn_in    : raw button pin, asynchronous to clk
//   go        : one-cycle pulse per accepted press (plus auto-repeats)
//   pressed   : debounced level, 1 while held (HELD or RELEASE_WAIT)
//   release_o : one-cycle pulse per accepted release
// Optional feature (macro BTN_AUTOREPEAT_EN): while HELD, go re-fires after
// REPEAT_DELAY cycles and then every REPEAT_PERIOD cycles. The REPEAT_*
// parameters exist only in that build.
// ---------------------------------------------------------------------------
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_BOARD,
  parameter int unsigned CNT_WIDTH       = 18,
  parameter int unsigned BTN_ACTIVE_LOW  = 1
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY    = 12500000,
  parameter int unsigned REPEAT_PERIOD   = 2500000
`endif
) (
  input  logic clk,
  input  logic rst_btn,
  input  logic btn_in,
  output logic go,
  output logic pressed,
  output logic release_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] DB_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  // Synchronizer resets to the idle pin level so s_pr reads "not pressed".
  localparam logic PIN_IDLE = (BTN_ACTIVE_LOW != 0);

  logic btn_sync;
  logic s_pr;

  sync2 #(
    .RESET_VAL (PIN_IDLE)
  ) u_sync2 (
    .clk   (clk),
    .rst_n (rst_btn),
    .d     (btn_in),
    .q     (btn_sync)
  );

  generate
    if (BTN_ACTIVE_LOW != 0) begin : g_active_low
      assign s_pr = ~btn_sync;
    end else begin : g_active_high
      assign s_pr = btn_sync;
    end
  endgenerate

  btn_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 go_q, go_d;
  logic                 pressed_q, pressed_d;
  logic                 release_q, release_d;
  logic                 go_press;
  logic                 rpt_fire;

  // Debounce FSM: a level change is accepted only after DEBOUNCE_CYCLES
  // consecutive samples of the new level; any opposite sample aborts.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    go_press  = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_pr) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!s_pr) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d  = HELD;
          cnt_d    = '0;
          go_press = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!s_pr) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (s_pr) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    go_d      = go_press | rpt_fire;
    pressed_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
  end

  always_ff @(posedge clk) begin
    if (!rst_btn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      go_q      <= 1'b0;
      pressed_q <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      go_q      <= go_d;
      pressed_q <= pressed_d;
      release_q <= release_d;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_WIDTH-1:0] RPT_DELAY_LAST  = CNT_WIDTH'(REPEAT_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] RPT_PERIOD_LAST = CNT_WIDTH'(REPEAT_PERIOD - 1);

  logic [CNT_WIDTH-1:0] rpt_cnt_q, rpt_cnt_d;
  logic                 rpt_armed_q, rpt_armed_d;  // first repeat already sent

  // Counts only while staying in HELD; anything else (including the cycle
  // that leaves or re-enters HELD) restarts the REPEAT_DELAY wait.
  always_comb begin
    rpt_cnt_d   = '0;
    rpt_armed_d = 1'b0;
    rpt_fire    = 1'b0;
    if ((state_q == HELD) && s_pr) begin
      if (rpt_cnt_q == (rpt_armed_q ? RPT_PERIOD_LAST : RPT_DELAY_LAST)) begin
        rpt_fire    = 1'b1;
        rpt_armed_d = 1'b1;
      end else begin
        rpt_cnt_d   = rpt_cnt_q + CNT_ONE;
        rpt_armed_d = rpt_armed_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_btn) begin
      rpt_cnt_q   <= '0;
      rpt_armed_q <= 1'b0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_armed_q <= rpt_armed_d;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  assign go        = go_q;
  assign pressed   = pressed_q;
  assign release_o = release_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// ---------------------------------------------------------------------------
// tb_btn_conditioner
// Directed scenarios (clean press, release, bounces, short glitch, reset
// mid-press, optional auto-repeat) followed by randomized button activity.
// Every cycle the DUT outputs are compared with a reference model that keeps
// the last DEBOUNCE_CYCLES synchronized samples and flips the debounced level
// when all of them disagree with it.
// ---------------------------------------------------------------------------
module tb_btn_conditioner;
  import btn_pkg::*;

  localparam int unsigned DB     = DEBOUNCE_CYCLES_SIM;
  localparam int unsigned ACT_LO = 1;
  localparam int unsigned RD     = 10;
  localparam int unsigned RP     = 5;

  logic clk     = 1'b0;
  logic rst_btn = 1'b0;
  logic btn_in  = 1'b1;
  logic go;
  logic pressed;
  logic release_o;

  always #5 clk = ~clk;

  btn_conditioner #(
    .DEBOUNCE_CYCLES (DB),
    .CNT_WIDTH       (18),
    .BTN_ACTIVE_LOW  (ACT_LO)
`ifdef BTN_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
`endif
  ) dut (
    .clk       (clk),
    .rst_btn   (rst_btn),
    .btn_in    (btn_in),
    .go        (go),
    .pressed   (pressed),
    .release_o (release_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_sync1, m_sync2;   // pressed-normalized synchronizer pipeline
  bit m_level;            // debounced level
  bit hist[$];            // most recent samples seen by the debouncer
  bit exp_go, exp_rel;
  bit m_held;             // in HELD with no pending release sample
  int m_elapsed;          // edges spent continuously in HELD

  // Per-phase counters of DUT pulses and step index of the first one.
  int go_cnt, rel_cnt, step_idx, first_go, first_rel;

  function automatic bit pin_to_pr(input logic b);
    return (ACT_LO != 0) ? !b : b;
  endfunction

  task automatic model_edge(input logic b, input logic r);
    bit samp;
    bit all_diff;
    samp    = m_sync2;
    exp_go  = 1'b0;
    exp_rel = 1'b0;
    if (!r) begin
      m_sync1 = 1'b0; m_sync2 = 1'b0; m_level = 1'b0;
      hist.delete(); m_held = 1'b0; m_elapsed = 0;
      return;
    end
    m_sync2 = m_sync1;
    m_sync1 = pin_to_pr(b);
    hist.push_back(samp);
    if (hist.size() > DB) void'(hist.pop_front());
    all_diff = (hist.size() == DB);
    foreach (hist[i]) if (hist[i] == m_level) all_diff = 1'b0;
    if (all_diff) begin
      m_level = !m_level;
      if (m_level) exp_go = 1'b1; else exp_rel = 1'b1;
      hist.delete();
      m_held = m_level;
      m_elapsed = 0;
    end else if (m_level) begin
      if (!samp) begin
        m_held = 1'b0; m_elapsed = 0;
      end else if (!m_held) begin
        m_held = 1'b1; m_elapsed = 0;
      end else begin
        m_elapsed++;
`ifdef BTN_AUTOREPEAT_EN
        if (m_elapsed == RD || (m_elapsed > RD && ((m_elapsed - RD) % RP) == 0))
          exp_go = 1'b1;
`endif
      end
    end
  endtask

  // One clock cycle: drive, let the edge happen, update model, compare.
  task automatic step(input logic b, input logic r);
    btn_in  = b;
    rst_btn = r;
    @(posedge clk);
    model_edge(b, r);
    @(negedge clk);
    step_idx++;
    check("go", go, exp_go);
    check("pressed", pressed, m_level);
    check("release", release_o, exp_rel);
    check("go_and_release", go & release_o, 0);
    if (go === 1'b1) begin
      go_cnt++;
      if (first_go == 0) first_go = step_idx;
    end
    if (release_o === 1'b1) begin
      rel_cnt++;
      if (first_rel == 0) first_rel = step_idx;
    end
  endtask

  task automatic phase_start();
    go_cnt = 0; rel_cnt = 0; step_idx = 0; first_go = 0; first_rel = 0;
  endtask

  task automatic phase_end(input string name);
    $display("phase %s: go=%0d release=%0d first_go=%0d first_release=%0d pressed=%0d",
             name, go_cnt, rel_cnt, first_go, first_rel, pressed);
  endtask

  logic pat[8];
  int   hold;
  logic lvl;

  initial begin
    pat = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    // Reset with button idle.
    phase_start();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
    check("reset_go_cnt", go_cnt, 0);
    phase_end("reset");

    // Clean press.
    phase_start();
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
    check("clean_go_cnt", go_cnt, 1);
    check("clean_latency", first_go, 6);
    check("clean_pressed", pressed, 1);
    phase_end("clean_press");

    // Release.
    phase_start();
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1);
    check("release_cnt", rel_cnt, 1);
    check("release_latency", first_rel, 6);
    check("release_go_cnt", go_cnt, 0);
    phase_end("release");

    // Bouncy press: bounces then stable low.
    phase_start();
    for (int i = 0; i < 8; i++) step(pat[i], 1'b1);
    check("bounce_no_go", go_cnt, 0);
    step_idx = 0;
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
    check("bounce_go_cnt", go_cnt, 1);
    check("bounce_latency", first_go, 6);
    phase_end("bouncy_press");
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1);

    // Short glitch.
    phase_start();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 15; i++) step(1'b1, 1'b1);
    check("glitch_go_cnt", go_cnt, 0);
    check("glitch_rel_cnt", rel_cnt, 0);
    phase_end("glitch");

    // Reset while in PRESS_WAIT with counter at 2.
    phase_start();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check("midreset_pressed", pressed, 0);
    step_idx = 0;
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1);
    check("midreset_go_cnt", go_cnt, 1);
    check("midreset_latency", first_go, 6);
    phase_end("reset_mid_press");

`ifdef BTN_AUTOREPEAT_EN
    // Auto-repeat: continuing the hold from the previous phase would mix
    // counts, so release first and start a fresh press.
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1);
    phase_start();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
    check("rpt_initial_go", go_cnt, 1);
    go_cnt = 0;
    for (int i = 0; i < 29; i++) step(1'b0, 1'b1);
    check("rpt_repeats", go_cnt, 4);
    go_cnt = 0;
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1);
    check("rpt_none_after_release", go_cnt, 0);
    phase_end("auto_repeat");
`else
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1);
`endif

    // Randomized activity: random hold lengths around the debounce window,
    // with occasional one-cycle resets.
    phase_start();
    lvl = 1'b1;
    for (int n = 0; n < 400; n++) begin
      lvl  = ~lvl;
      hold = $urandom_range(1, 2 * DB + 2);
      for (int k = 0; k < hold; k++) begin
        if ($urandom_range(0, 59) == 0) step(lvl, 1'b0);
        else                            step(lvl, 1'b1);
      end
    end
    phase_end("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
